step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL provide parameter NUM_STEPS, default 8, meaning the number of one-hot timing steps T0..T(NUM_STEPS-1); legal range 2..16.
REQ-002 SHALL provide parameter CLEAR_CYCLES, default 2, meaning the clear-pulse length after reset release; legal range 1..15.
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: stop  input  1  level; requests halt at the next instruction boundary.
REQ-007 SHALL have port: resume  input  1  level; leaves HALT.
REQ-008 SHALL have port: end_instr  input  1  from decoder; the current step is the last of the instruction.
REQ-009 SHALL have port: mem_wait  input  1  stall; holds the current step.
REQ-010 SHALL have port: T  output  NUM_STEPS  one-hot step vector.
REQ-011 SHALL have port: step_idx  output  $clog2(NUM_STEPS)  binary index of the active step.
REQ-012 SHALL have port: run  output  1  high in RUN state.
REQ-013 SHALL have port: clear  output  1  high in CLEAR state.
REQ-014 SHALL have port: instr_done  output  1  one-cycle pulse per retired instruction.
REQ-015 SHALL have port: instr_count  output  CNT_W  retired-instruction count.
REQ-016 SHALL have port: step_ovf  output  1  sticky error flag; forced wrap occurred.

Function
REQ-017 SHALL implement states CLEAR, RUN, HALT; all outputs registered.
REQ-018 CLEAR: clear=1, run=0, T=0; after exactly CLEAR_CYCLES cycles SHALL go to RUN with T=T0.
REQ-019 RUN: run=1, exactly one T bit high, step_idx equal to its index.
REQ-020 RUN, mem_wait=1: T, step_idx, instr_count SHALL hold; no instr_done.
REQ-021 RUN, mem_wait=0, end_instr=0, not last step: SHALL advance Tk -> Tk+1 next cycle.
REQ-022 RUN, mem_wait=0, end_instr=1: SHALL retire the instruction:
  - instr_done=1 next cycle;
  - instr_count +1 modulo 2^CNT_W;
  - next step T0.
REQ-023 RUN, mem_wait=0, end_instr=0 at T(NUM_STEPS-1): SHALL force a wrap to T0, set step_ovf, and SHALL NOT pulse instr_done or increment instr_count.
REQ-024 mem_wait and end_instr high together: mem_wait SHALL win (hold; end_instr ignored that cycle).
REQ-025 stop high in any RUN cycle SHALL set an internal stop_pending latch.
REQ-026 When an instruction retires (REQ-022) with stop_pending or stop set: the instruction SHALL be counted, then state HALT; stop_pending cleared.
REQ-027 HALT: run=0, T=0, step_idx=0; instr_count and step_ovf held.
REQ-028 HALT with resume=1 and stop=0: SHALL enter RUN at T0 next cycle; resume ignored while stop=1 or outside HALT.
REQ-029 Forced wrap (REQ-023) SHALL NOT honor stop_pending; halt occurs only on a genuine retire.
REQ-030 instr_done SHALL be high at most one cycle per retire; it SHALL be 0 in CLEAR and HALT.

Reset
REQ-031 reset low SHALL immediately, asynchronously force:
  - state CLEAR with the clear counter reloaded;
  - clear=1, run=0, T=0, step_idx=0;
  - instr_done=0, instr_count=0, step_ovf=0;
  - stop_pending=0.
REQ-032 Reset asserted mid-instruction or mid-stall SHALL discard the instruction without counting it; the CLEAR sequence SHALL restart after release.
REQ-033 The first rising clk edge after reset rises SHALL begin counting CLEAR_CYCLES.

Verification
REQ-034 Defaults, release reset, inputs low -> clear=1 for 2 cycles, then T=8'h01, T steps 01,02,04,...,80, then 01 with step_ovf=1 and instr_count=0.
REQ-035 end_instr=1 at T2 (T=8'h04) -> next cycle T=8'h01, instr_done=1 for one cycle, instr_count=1.
REQ-036 mem_wait=1 for 3 cycles at T1 with end_instr=1 -> T=8'h02 held 3 cycles, no instr_done; retire on the 4th cycle after mem_wait falls.
REQ-037 stop pulsed one cycle at T1, end_instr at T3 -> instr_count increments, state HALT (run=0, T=0); resume=1 -> T=8'h01 next cycle.
REQ-038 CNT_W=4, 16 retires -> instr_count wraps 15 -> 0; instr_done pulses each time.
REQ-039 reset low during T5 with mem_wait=1 -> outputs reset immediately (same cycle, asynchronous); instr_count=0; clear sequence repeats after release.

Source files
------------

// File: rtl/step_sequencer.sv
// One-hot instruction step sequencer with a CLEAR/RUN/HALT control FSM.
// Counts retired instructions and flags forced step wraps.
module step_sequencer #(
   parameter int NUM_STEPS    = 8,
   parameter int CLEAR_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stop,
   input  logic                         resume,
   input  logic                         end_instr,
   input  logic                         mem_wait,
   output logic [NUM_STEPS-1:0]         T,
   output logic [$clog2(NUM_STEPS)-1:0] step_idx,
   output logic                         run,
   output logic                         clear,
   output logic                         instr_done,
   output logic [CNT_W-1:0]             instr_count,
   output logic                         step_ovf
);

   localparam int IW = $clog2(NUM_STEPS);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STEPS - 1);
   localparam logic [3:0]    CLR_RELOAD = 4'(CLEAR_CYCLES - 1);

   typedef enum logic [1:0] {S_CLEAR, S_RUN, S_HALT} state_t;

   state_t               state, state_n;
   logic [3:0]           clr_cnt, clr_cnt_n;
   logic [NUM_STEPS-1:0] t_q, t_n;
   logic [IW-1:0]        idx_q, idx_n;
   logic                 done_q, done_n;
   logic [CNT_W-1:0]     count_q, count_n;
   logic                 ovf_q, ovf_n;
   logic                 pend_q, pend_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_CLEAR;
         clr_cnt <= CLR_RELOAD;
         t_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state   <= state_n;
         clr_cnt <= clr_cnt_n;
         t_q     <= t_n;
         idx_q   <= idx_n;
         done_q  <= done_n;
         count_q <= count_n;
         ovf_q   <= ovf_n;
         pend_q  <= pend_n;
      end
   end

   always_comb begin
      state_n   = state;
      clr_cnt_n = clr_cnt;
      t_n       = t_q;
      idx_n     = idx_q;
      done_n    = 1'b0;
      count_n   = count_q;
      ovf_n     = ovf_q;
      pend_n    = pend_q;
      case (state)
         S_CLEAR: begin
            if (clr_cnt == 4'd0) begin
               state_n = S_RUN;
               t_n     = NUM_STEPS'(1);
               idx_n   = '0;
            end else begin
               clr_cnt_n = clr_cnt - 4'd1;
            end
         end
         S_RUN: begin
            if (mem_wait) begin
               pend_n = pend_q | stop;
            end else if (end_instr) begin
               done_n  = 1'b1;
               count_n = count_q + CNT_W'(1);
               t_n     = NUM_STEPS'(1);
               idx_n   = '0;
               // A stop seen during this instruction (or right now) halts after it retires.
               if (pend_q || stop) begin
                  state_n = S_HALT;
                  t_n     = '0;
                  pend_n  = 1'b0;
               end
            end else if (idx_q == LAST_IDX) begin
               t_n    = NUM_STEPS'(1);
               idx_n  = '0;
               ovf_n  = 1'b1;
               pend_n = pend_q | stop;
            end else begin
               t_n    = t_q << 1;
               idx_n  = idx_q + IW'(1);
               pend_n = pend_q | stop;
            end
         end
         S_HALT: begin
            if (resume && !stop) begin
               state_n = S_RUN;
               t_n     = NUM_STEPS'(1);
               idx_n   = '0;
            end
         end
         default: state_n = S_CLEAR;
      endcase
   end

   assign T           = t_q;
   assign step_idx    = idx_q;
   assign run         = (state == S_RUN);
   assign clear       = (state == S_CLEAR);
   assign instr_done  = done_q;
   assign instr_count = count_q;
   assign step_ovf    = ovf_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized bench for step_sequencer against a mode/step/count reference model.
module tb_step_sequencer;

   localparam int N  = 8;
   localparam int CC = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stop = 1'b0, resume = 1'b0, end_instr = 1'b0, mem_wait = 1'b0;
   logic [N-1:0]  T;
   logic [2:0]    step_idx;
   logic          run, clear, instr_done, step_ovf;
   logic [CW-1:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 = clearing, 1 = running, 2 = halted
   int m_mode, m_clr, m_step, m_count;
   bit m_ovf, m_pend, m_done;

   step_sequencer #(.NUM_STEPS(N), .CLEAR_CYCLES(CC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .stop(stop), .resume(resume),
      .end_instr(end_instr), .mem_wait(mem_wait), .T(T), .step_idx(step_idx),
      .run(run), .clear(clear), .instr_done(instr_done),
      .instr_count(instr_count), .step_ovf(step_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_clr = CC; m_step = 0; m_count = 0;
      m_ovf = 0; m_pend = 0; m_done = 0;
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
         return;
      end
      m_done = 0;
      case (m_mode)
         0: begin
            m_clr--;
            if (m_clr == 0) begin m_mode = 1; m_step = 0; end
         end
         1: begin
            if (mem_wait) m_pend = m_pend | stop;
            else if (end_instr) begin
               m_count = (m_count + 1) % (1 << CW);
               m_done  = 1;
               m_step  = 0;
               if (m_pend || stop) begin m_mode = 2; m_pend = 0; end
            end else begin
               m_pend = m_pend | stop;
               if (m_step == N - 1) begin m_step = 0; m_ovf = 1; end
               else m_step++;
            end
         end
         default: if (resume && !stop) begin m_mode = 1; m_step = 0; end
      endcase
   endtask

   task automatic check_all();
      logic [31:0] exp_t;
      exp_t = (m_mode == 1) ? (32'd1 << m_step) : 32'd0;
      check("T", 32'(T), exp_t);
      check("step_idx", 32'(step_idx), (m_mode == 1) ? 32'(m_step) : 32'd0);
      check("run", 32'(run), 32'(m_mode == 1));
      check("clear", 32'(clear), 32'(m_mode == 0));
      check("instr_done", 32'(instr_done), 32'(m_done));
      check("instr_count", 32'(instr_count), 32'(m_count));
      check("step_ovf", 32'(step_ovf), 32'(m_ovf));
   endtask

   task automatic tick(input bit s, input bit r, input bit e, input bit m);
      stop = s; resume = r; end_instr = e; mem_wait = m;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Called 1ns after an edge; reset falls between edges to exercise the async path.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      tick(0, 0, 0, mem_wait);
      tick(0, 0, 0, 0);
      reset = 1'b1;
   endtask

   task automatic go_to(input int k);
      for (int i = 0; i < 20 && !(m_mode == 1 && m_step == k); i++) tick(0, 0, 0, 0);
      check("go_to", 32'(m_mode == 1 && m_step == k), 32'd1);
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b0;
      #1 check_all();
      tick(0, 0, 0, 0);
      reset = 1'b1;

      // Clear pulse, full step walk, forced wrap
      for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);

      // Retire at T2
      go_to(2);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);

      // Stall at T1 with end_instr, then retire
      go_to(1);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);

      // Stop pulse at T1, retire at T3, halt, resume
      go_to(1);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      tick(1, 1, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);

      // Counter wrap with 4-bit count
      for (int i = 0; i < 18; i++) tick(0, 0, 1, 0);

      // Reset during a stall at T5
      go_to(5);
      tick(0, 0, 0, 1);
      async_reset();
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset();
         else tick($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
